// File: rtl/axi_lite_rr_arbiter_if.sv
// rtl/axi_lite_rr_arbiter_if.sv - N-master / 1-slave AXI-lite bundle for axi_lite_rr_arbiter
interface axi_lite_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64
);
    localparam int STRB_W = DATA_W / 8;

    // Upstream side: one lane per master, master i at [i*W +: W]
    logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
    logic [NUM_MASTERS-1:0]        m_arvalid;
    logic [NUM_MASTERS-1:0]        m_arready;
    logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
    logic [NUM_MASTERS*2-1:0]      m_rresp;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic [NUM_MASTERS-1:0]        m_rready;
    logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr;
    logic [NUM_MASTERS-1:0]        m_awvalid;
    logic [NUM_MASTERS-1:0]        m_awready;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*STRB_W-1:0] m_wstrb;
    logic [NUM_MASTERS-1:0]        m_wvalid;
    logic [NUM_MASTERS-1:0]        m_wready;
    logic [NUM_MASTERS*2-1:0]      m_bresp;
    logic [NUM_MASTERS-1:0]        m_bvalid;
    logic [NUM_MASTERS-1:0]        m_bready;

    // Downstream side: the single shared slave port
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    // Arbiter view: it masters the shared s_* port on behalf of the m_* lanes
    modport master (
        input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        input  m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready,
        output m_bresp, m_bvalid,
        output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
        output s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready,
        input  s_bresp, s_bvalid
    );

    // Environment view: requesting masters plus the downstream slave
    modport slave (
        output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        output m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready,
        input  m_bresp, m_bvalid,
        input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
        input  s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready,
        output s_bresp, s_bvalid
    );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - N-master round-robin AXI-lite arbiter, optional watchdog via ARB_TIMEOUT_EN
module axi_lite_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GID_W         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_rr_arbiter_if.master     bus,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RD = 2'd1,
        GRANT_WR = 2'd2
    } state_t;

    state_t             state;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   sel;
    logic [GID_W-1:0]   nxt_ptr;
    logic               any_req;
    logic               done;
    logic [NUM_MASTERS-1:0] req_rd;
    logic [NUM_MASTERS-1:0] req_wr;
    logic [NUM_MASTERS-1:0] req;
    int                 sel_idx;
    int                 g;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Counter saturates at the limit; the timeout response is decoded from it
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));
`endif

    assign req_rd  = bus.m_arvalid;
    assign req_wr  = bus.m_awvalid | bus.m_wvalid;
    assign req     = req_rd | req_wr;
    assign g       = int'(grant_id);
    assign nxt_ptr = (grant_id == GID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;

    // Round-robin pick: first requester at rr_ptr, rr_ptr+1, ... (descending scan so the nearest wins)
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        sel_idx = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            sel_idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (req[sel_idx]) begin
                any_req = 1'b1;
                sel     = GID_W'(sel_idx);
            end
        end
    end

    // Route the granted master's channels to the slave; everything else held at zero
    always_comb begin
        bus.m_arready = '0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rvalid  = '0;
        bus.m_awready = '0;
        bus.m_wready  = '0;
        bus.m_bresp   = '0;
        bus.m_bvalid  = '0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        done          = 1'b0;
        case (state)
            GRANT_RD: begin
`ifdef ARB_TIMEOUT_EN
                if (to_hit) begin
                    bus.m_rvalid[g]        = 1'b1;
                    bus.m_rresp[g*2 +: 2]  = 2'b10;
                    done                   = bus.m_rready[g];
                end else
`endif
                begin
                    bus.s_araddr                  = bus.m_araddr[g*ADDR_W +: ADDR_W];
                    bus.s_arvalid                 = bus.m_arvalid[g];
                    bus.m_arready[g]              = bus.s_arready;
                    bus.m_rdata[g*DATA_W +: DATA_W] = bus.s_rdata;
                    bus.m_rresp[g*2 +: 2]         = bus.s_rresp;
                    bus.m_rvalid[g]               = bus.s_rvalid;
                    bus.s_rready                  = bus.m_rready[g];
                    done                          = bus.s_rvalid & bus.m_rready[g];
                end
            end
            GRANT_WR: begin
`ifdef ARB_TIMEOUT_EN
                if (to_hit) begin
                    bus.m_bvalid[g]        = 1'b1;
                    bus.m_bresp[g*2 +: 2]  = 2'b10;
                    done                   = bus.m_bready[g];
                end else
`endif
                begin
                    bus.s_awaddr          = bus.m_awaddr[g*ADDR_W +: ADDR_W];
                    bus.s_awvalid         = bus.m_awvalid[g];
                    bus.m_awready[g]      = bus.s_awready;
                    bus.s_wdata           = bus.m_wdata[g*DATA_W +: DATA_W];
                    bus.s_wstrb           = bus.m_wstrb[g*(DATA_W/8) +: (DATA_W/8)];
                    bus.s_wvalid          = bus.m_wvalid[g];
                    bus.m_wready[g]       = bus.s_wready;
                    bus.m_bresp[g*2 +: 2] = bus.s_bresp;
                    bus.m_bvalid[g]       = bus.s_bvalid;
                    bus.s_bready          = bus.m_bready[g];
                    done                  = bus.s_bvalid & bus.m_bready[g];
                end
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // Grant FSM: select in IDLE, hold until the slave's own completion handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= sel;
                        busy     <= 1'b1;
                        state    <= req_rd[sel] ? GRANT_RD : GRANT_WR;
`ifdef ARB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                GRANT_RD, GRANT_WR: begin
                    if (done) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= nxt_ptr;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (!to_hit) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - directed self-checking bench for axi_lite_rr_arbiter
module tb_axi_lite_rr_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;

    logic       clk;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    int         checks;
    int         errors;
    logic [1:0] exp_ids [4];

    axi_lite_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_lite_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd0};
        rst = 1'b1;
        bus.m_araddr = '0; bus.m_arvalid = '0; bus.m_rready = '0;
        bus.m_awaddr = '0; bus.m_awvalid = '0; bus.m_wdata = '0;
        bus.m_wstrb = '0; bus.m_wvalid = '0; bus.m_bready = '0;
        bus.s_arready = 1'b0; bus.s_rdata = '0; bus.s_rresp = '0; bus.s_rvalid = 1'b0;
        bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bresp = '0; bus.s_bvalid = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_s_arvalid", 64'(bus.s_arvalid), 64'd0);
        chk("rst_m_arready", 64'(bus.m_arready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Master 0 read, data returned after 3 cycles
        bus.m_araddr[0*AW +: AW] = 32'h8000_0000;
        bus.m_arvalid[0] = 1'b1;
        bus.m_rready[0]  = 1'b1;
        bus.s_arready    = 1'b1;
        tick();
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_gid", 64'(grant_id), 64'd0);
        chk("rd_s_araddr", 64'(bus.s_araddr), 64'h8000_0000);
        chk("rd_m_arready", 64'(bus.m_arready), 64'b001);
        tick();
        bus.m_arvalid[0] = 1'b0;
        tick();
        tick();
        bus.s_rdata  = 64'h1122_3344_5566_7788;
        bus.s_rresp  = 2'b00;
        bus.s_rvalid = 1'b1;
        #1;
        chk("rd_m_rdata0", bus.m_rdata[63:0], 64'h1122_3344_5566_7788);
        chk("rd_m_rresp0", 64'(bus.m_rresp[1:0]), 64'd0);
        chk("rd_m_rvalid", 64'(bus.m_rvalid), 64'b001);
        chk("rd_m_rdata1", bus.m_rdata[127:64], 64'd0);
        tick();
        bus.s_rvalid = 1'b0;
        #1;
        chk("rd_done_busy", 64'(busy), 64'd0);
        chk("rd_done_rdata", bus.m_rdata[63:0], 64'd0);

        // Master 1 write while master 0 also asks to read (rr_ptr now 1)
        bus.m_araddr[0*AW +: AW] = 32'h8000_0020;
        bus.m_arvalid[0] = 1'b1;
        bus.m_awaddr[1*AW +: AW] = 32'h8000_0010;
        bus.m_wdata[1*DW +: DW]  = 64'hDEAD_BEEF;
        bus.m_wstrb[1*8 +: 8]    = 8'h0F;
        bus.m_awvalid[1] = 1'b1;
        bus.m_wvalid[1]  = 1'b1;
        bus.m_bready[1]  = 1'b1;
        bus.s_awready = 1'b1;
        bus.s_wready  = 1'b1;
        tick();
        chk("wr_gid", 64'(grant_id), 64'd1);
        chk("wr_s_awaddr", 64'(bus.s_awaddr), 64'h8000_0010);
        chk("wr_s_wdata", bus.s_wdata, 64'hDEAD_BEEF);
        chk("wr_s_wstrb", 64'(bus.s_wstrb), 64'h0F);
        chk("wr_s_arvalid_iso", 64'(bus.s_arvalid), 64'd0);
        chk("wr_m_arready0", 64'(bus.m_arready), 64'd0);
        chk("wr_m_awready", 64'(bus.m_awready), 64'b010);
        chk("wr_m_wready", 64'(bus.m_wready), 64'b010);
        tick();
        bus.m_awvalid[1] = 1'b0;
        bus.m_wvalid[1]  = 1'b0;
        bus.s_bresp  = 2'b00;
        bus.s_bvalid = 1'b1;
        #1;
        chk("wr_m_bvalid", 64'(bus.m_bvalid), 64'b010);
        chk("wr_m_bresp1", 64'(bus.m_bresp[3:2]), 64'd0);
        tick();
        bus.s_bvalid = 1'b0;
        #1;
        chk("wr_done_busy", 64'(busy), 64'd0);
        tick();
        chk("wr_next_gid", 64'(grant_id), 64'd0);
        chk("wr_next_s_araddr", 64'(bus.s_araddr), 64'h8000_0020);
        tick();
        bus.m_arvalid[0] = 1'b0;
        bus.s_rvalid = 1'b1;
        tick();
        bus.s_rvalid = 1'b0;

        // Master 2 read and write together: read first, write on a later grant
        bus.m_araddr[2*AW +: AW] = 32'h8000_0030;
        bus.m_awaddr[2*AW +: AW] = 32'h8000_0038;
        bus.m_wdata[2*DW +: DW]  = 64'hCAFE;
        bus.m_wstrb[2*8 +: 8]    = 8'hFF;
        bus.m_arvalid[2] = 1'b1;
        bus.m_awvalid[2] = 1'b1;
        bus.m_wvalid[2]  = 1'b1;
        bus.m_rready[2]  = 1'b1;
        bus.m_bready[2]  = 1'b1;
        tick();
        chk("rw_rd_gid", 64'(grant_id), 64'd2);
        chk("rw_rd_s_arvalid", 64'(bus.s_arvalid), 64'd1);
        chk("rw_rd_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        tick();
        bus.m_arvalid[2] = 1'b0;
        bus.s_rvalid = 1'b1;
        tick();
        bus.s_rvalid = 1'b0;
        #1;
        chk("rw_gap_busy", 64'(busy), 64'd0);
        tick();
        chk("rw_wr_gid", 64'(grant_id), 64'd2);
        chk("rw_wr_s_awvalid", 64'(bus.s_awvalid), 64'd1);
        chk("rw_wr_s_awaddr", 64'(bus.s_awaddr), 64'h8000_0038);
        tick();
        bus.m_awvalid[2] = 1'b0;
        bus.m_wvalid[2]  = 1'b0;
        bus.s_bvalid = 1'b1;
        tick();
        bus.s_bvalid = 1'b0;

        // Asynchronous reset in the middle of a write grant
        bus.m_awvalid[1] = 1'b1;
        bus.m_wvalid[1]  = 1'b1;
        tick();
        chk("rs_pre_busy", 64'(busy), 64'd1);
        chk("rs_pre_gid", 64'(grant_id), 64'd1);
        bus.s_bvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_gid", 64'(grant_id), 64'd0);
        chk("rs_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        chk("rs_m_awready", 64'(bus.m_awready), 64'd0);
        chk("rs_m_bvalid", 64'(bus.m_bvalid), 64'd0);
        bus.m_awvalid[1] = 1'b0;
        bus.m_wvalid[1]  = 1'b0;
        bus.s_bvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Three readers held: rotation restarts at master 0
        bus.m_arvalid = 3'b111;
        bus.m_rready  = 3'b111;
        bus.s_arready = 1'b1;
        bus.s_rvalid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_gid%0d", k), 64'(grant_id), 64'(exp_ids[k]));
            chk($sformatf("rr_busy%0d", k), 64'(busy), 64'd1);
            tick();
            chk($sformatf("rr_idle%0d", k), 64'(busy), 64'd0);
        end
        bus.m_arvalid = '0;
        bus.s_rvalid  = 1'b0;
        bus.m_rready  = '0;

        // Slave never responds to master 1's read
        bus.s_arready = 1'b0;
        bus.m_arvalid[1] = 1'b1;
        tick();
        chk("to_gid", 64'(grant_id), 64'd1);
`ifdef ARB_TIMEOUT_EN
        repeat (15) tick();
        chk("to_pre_rvalid", 64'(bus.m_rvalid), 64'd0);
        tick();
        chk("to_rvalid", 64'(bus.m_rvalid), 64'b010);
        chk("to_rresp", 64'(bus.m_rresp[3:2]), 64'b10);
        chk("to_rdata", bus.m_rdata[127:64], 64'd0);
        chk("to_s_arvalid", 64'(bus.s_arvalid), 64'd0);
        bus.m_rready[1]  = 1'b1;
        bus.m_arvalid[1] = 1'b0;
        tick();
        chk("to_done_busy", 64'(busy), 64'd0);
`else
        repeat (20) tick();
        chk("hang_busy", 64'(busy), 64'd1);
        chk("hang_gid", 64'(grant_id), 64'd1);
        chk("hang_rvalid", 64'(bus.m_rvalid), 64'd0);
        bus.m_arvalid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("hang_rst_busy", 64'(busy), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
